// File: rtl/timer_pkg.sv
// Shared types and defaults for the timer block and its command sequencer.
package timer_pkg;

   localparam int TIMER_DATA_WIDTH = 8;

   typedef enum logic [3:0] {
      IDLE,
      LOAD,
      DONE_SKIP,
      RUN,
      PAUSE_STOP,
      PAUSED,
      RESUME,
      DONE,
      ABORT
   } seq_state_e;

endpackage

// File: rtl/timer_seq_fifo.sv
// Small synchronous FIFO holding pending timer periods; head is visible combinationally.
module timer_seq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (level_q == LW'(DEPTH));
   assign empty   = (level_q == '0);
   assign level   = level_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Flush dominates any concurrent push or pop.
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         level_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         if (do_push && !do_pop)      level_d = level_q + LW'(1);
         else if (do_pop && !do_push) level_d = level_q - LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/timer_sequencer.sv
// Issues buffered periods to the timer one at a time, handling pause, zero-skip and abort.
module timer_sequencer #(
   parameter int DATA_WIDTH = timer_pkg::TIMER_DATA_WIDTH,
   parameter int DEPTH      = 4,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_WIDTH-1:0]   in_data,
   input  logic                    pause,
   input  logic                    abort,
   output logic                    timer_start,
   output logic                    timer_stop,
   output logic [DATA_WIDTH-1:0]   timer_data,
   input  logic                    timer_done,
   output logic                    seq_done,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  level,
   output logic [CNT_WIDTH-1:0]    completed
);

   import timer_pkg::*;

   seq_state_e            state_q, state_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [CNT_WIDTH-1:0]  completed_q, completed_d;
   logic                  blank_q, blank_d;
   logic                  start_q, start_d;
   logic                  stop_q, stop_d;
   logic                  seq_done_q, seq_done_d;
   logic                  busy_q, busy_d;

   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  fifo_flush;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_rd_data;

   assign in_ready  = !fifo_full && !abort;
   assign fifo_push = in_valid && in_ready;

   timer_seq_fifo #(
      .W     (DATA_WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (fifo_push),
      .pop     (fifo_pop),
      .flush   (fifo_flush),
      .wr_data (in_data),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (level)
   );

   always_comb begin
      state_d     = state_q;
      data_d      = data_q;
      completed_d = completed_q;
      fifo_pop    = 1'b0;
      fifo_flush  = 1'b0;
      if (abort) begin
         fifo_flush = 1'b1;
         state_d    = (state_q == IDLE) ? IDLE : ABORT;
      end else begin
         unique case (state_q)
            IDLE, DONE, DONE_SKIP: begin
               if (!fifo_empty) begin
                  state_d  = LOAD;
                  fifo_pop = 1'b1;
                  data_d   = fifo_rd_data;
               end else begin
                  state_d = IDLE;
               end
            end
            LOAD:       state_d = (data_q == '0) ? DONE_SKIP : RUN;
            // A done in the first cycle after a start belongs to the previous run.
            RUN: begin
               if (timer_done && !blank_q) state_d = DONE;
               else if (pause)             state_d = PAUSE_STOP;
            end
            PAUSE_STOP: state_d = PAUSED;
            PAUSED:     if (!pause) state_d = RESUME;
            RESUME:     state_d = RUN;
            ABORT:      state_d = IDLE;
            default:    state_d = IDLE;
         endcase
      end

      if (state_d == DONE) completed_d = completed_q + CNT_WIDTH'(1);

      // Outputs are registered copies of the next-state decode, so they track state only.
      blank_d    = (state_q == LOAD) || (state_q == RESUME);
      start_d    = ((state_d == LOAD) && (data_d != '0)) || (state_d == RESUME);
      stop_d     = (state_d == PAUSE_STOP) || (state_d == ABORT);
      seq_done_d = (state_d == DONE);
      busy_d     = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         data_q      <= '0;
         completed_q <= '0;
         blank_q     <= 1'b0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         seq_done_q  <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         data_q      <= data_d;
         completed_q <= completed_d;
         blank_q     <= blank_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         seq_done_q  <= seq_done_d;
         busy_q      <= busy_d;
      end
   end

   assign timer_start = start_q;
   assign timer_stop  = stop_q;
   assign timer_data  = data_q;
   assign seq_done    = seq_done_q;
   assign busy        = busy_q;
   assign completed   = completed_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed scenarios plus a randomized run against a behavioural timer and period queue.
module tb_timer_sequencer;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int CW    = 16;
   localparam int N_RND = 40;
   localparam int RND_BUDGET = 20000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          pause = 1'b0;
   logic          abort = 1'b0;
   logic          timer_start;
   logic          timer_stop;
   logic [DW-1:0] timer_data;
   logic          timer_done = 1'b0;
   logic          seq_done;
   logic          busy;
   logic [$clog2(DEPTH):0] level;
   logic [CW-1:0] completed;

   always #5 clk = ~clk;

   timer_sequencer #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .CNT_WIDTH  (CW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .pause       (pause),
      .abort       (abort),
      .timer_start (timer_start),
      .timer_stop  (timer_stop),
      .timer_data  (timer_data),
      .timer_done  (timer_done),
      .seq_done    (seq_done),
      .busy        (busy),
      .level       (level),
      .completed   (completed)
   );

   int            n_vec = 0;
   int            n_mis = 0;
   int            n_start = 0;
   int            n_stop = 0;
   int            n_sdone = 0;
   logic [DW-1:0] last_start = '0;
   int            s_start, s_stop, s_sd;
   logic [DW-1:0] t2_w [5];

   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] cur = '0;
   int            cnt = 0;
   int            sent = 0;
   int            n_done = 0;
   int            budget = 0;
   int            leftover = 0;
   int            n_txn = 0;
   bit            run = 1'b0;
   bit            held = 1'b0;
   bit            accepted = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      if (timer_start) begin
         n_start++;
         last_start = timer_data;
      end
      if (timer_stop) n_stop++;
      if (seq_done)   n_sdone++;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
   endtask

   task automatic pulse_done();
      timer_done = 1'b1;
      cyc();
      timer_done = 1'b0;
   endtask

   task automatic wait_start(input string tag, input int limit);
      int i = 0;
      while (!timer_start && i < limit) begin
         cyc();
         i++;
      end
      chk({tag, "_start_seen"}, 32'(timer_start), 32'd1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_start"},     32'(timer_start), 32'd0);
      chk({tag, "_stop"},      32'(timer_stop),  32'd0);
      chk({tag, "_data"},      32'(timer_data),  32'd0);
      chk({tag, "_seq_done"},  32'(seq_done),    32'd0);
      chk({tag, "_busy"},      32'(busy),        32'd0);
      chk({tag, "_level"},     32'(level),       32'd0);
      chk({tag, "_completed"}, 32'(completed),   32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),    32'd1);
   endtask

   initial begin
      t2_w[0] = 8'h03; t2_w[1] = 8'h05; t2_w[2] = 8'h07; t2_w[3] = 8'h09; t2_w[4] = 8'h0B;

      // Reset state
      repeat (2) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      cyc();

      // Single period, with a done pulse inside the blanking cycle
      push_word(8'h0A);
      chk("t1_no_early_start", 32'(timer_start), 32'd0);
      chk("t1_level",          32'(level),       32'd1);
      cyc();
      chk("t1_start",          32'(timer_start), 32'd1);
      chk("t1_data",           32'(timer_data),  32'h0A);
      cyc();
      chk("t1_start_width",    32'(timer_start), 32'd0);
      timer_done = 1'b1;
      cyc();
      timer_done = 1'b0;
      chk("t1_blanked_done",   32'(seq_done),    32'd0);
      chk("t1_busy_run",       32'(busy),        32'd1);
      pulse_done();
      chk("t1_seq_done",       32'(seq_done),    32'd1);
      chk("t1_completed",      32'(completed),   32'd1);
      cyc();
      chk("t1_seq_done_width", 32'(seq_done),    32'd0);
      chk("t1_idle",           32'(busy),        32'd0);
      $display("txn t1: period 0x0A issued and completed");

      // Fill the FIFO, then back-to-back periods
      s_start = n_start;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = t2_w[i];
         cyc();
      end
      in_data = 8'h0D;
      chk("t2_full_level",     32'(level),       32'd4);
      chk("t2_full_ready",     32'(in_ready),    32'd0);
      cyc();
      chk("t2_no_push_full",   32'(level),       32'd4);
      in_valid = 1'b0;
      chk("t2_first_starts",   32'(n_start - s_start), 32'd1);
      chk("t2_first_data",     32'(last_start),  32'h03);
      pulse_done();
      chk("t2_seq_done_0",     32'(seq_done),    32'd1);
      for (int i = 1; i < 5; i++) begin
         cyc();
         chk($sformatf("t2_start_%0d", i), 32'(timer_start), 32'd1);
         chk($sformatf("t2_data_%0d", i),  32'(timer_data),  32'(t2_w[i]));
         cyc();
         cyc();
         pulse_done();
         chk($sformatf("t2_seq_done_%0d", i), 32'(seq_done), 32'd1);
      end
      cyc();
      chk("t2_idle",           32'(busy),        32'd0);
      chk("t2_completed",      32'(completed),   32'd6);
      $display("txn t2: five queued periods issued in order");

      // Pause in the middle of a period
      push_word(8'h0F);
      cyc();
      chk("t3_start",          32'(timer_start), 32'd1);
      s_start = n_start;
      s_stop  = n_stop;
      repeat (4) cyc();
      pause = 1'b1;
      cyc();
      chk("t3_stop",           32'(timer_stop),  32'd1);
      chk("t3_data_stop",      32'(timer_data),  32'h0F);
      cyc();
      cyc();
      pause = 1'b0;
      cyc();
      chk("t3_resume",         32'(timer_start), 32'd1);
      chk("t3_data_resume",    32'(timer_data),  32'h0F);
      chk("t3_one_stop",       32'(n_stop - s_stop),   32'd1);
      chk("t3_one_restart",    32'(n_start - s_start), 32'd1);
      cyc();
      cyc();
      pulse_done();
      chk("t3_seq_done",       32'(seq_done),    32'd1);
      chk("t3_completed",      32'(completed),   32'd7);
      cyc();
      $display("txn t3: period 0x0F paused and resumed");

      // Done and pause together: done wins
      push_word(8'h06);
      cyc();
      cyc();
      cyc();
      s_stop = n_stop;
      timer_done = 1'b1;
      pause = 1'b1;
      cyc();
      timer_done = 1'b0;
      pause = 1'b0;
      chk("t4_seq_done",       32'(seq_done),    32'd1);
      cyc();
      cyc();
      chk("t4_no_stop",        32'(n_stop - s_stop), 32'd0);
      chk("t4_completed",      32'(completed),   32'd8);
      chk("t4_idle",           32'(busy),        32'd0);
      $display("txn t4: simultaneous done and pause");

      // Zero period is skipped
      s_start = n_start;
      s_sd    = n_sdone;
      push_word(8'h00);
      push_word(8'h04);
      chk("t5_zero_no_start",  32'(timer_start), 32'd0);
      wait_start("t5", 10);
      chk("t5_data",           32'(timer_data),  32'h04);
      chk("t5_one_start",      32'(n_start - s_start), 32'd1);
      chk("t5_no_seq_done",    32'(n_sdone - s_sd),    32'd0);
      chk("t5_completed_held", 32'(completed),   32'd8);
      cyc();
      cyc();
      pulse_done();
      chk("t5_completed",      32'(completed),   32'd9);
      cyc();
      $display("txn t5: zero skipped, 0x04 issued");

      // Abort mid-run with words queued
      in_valid = 1'b1;
      in_data = 8'h10;
      cyc();
      in_data = 8'h11;
      cyc();
      chk("t6_start",          32'(timer_data),  32'h10);
      in_data = 8'h12;
      cyc();
      in_valid = 1'b0;
      repeat (6) cyc();
      s_stop = n_stop;
      s_sd   = n_sdone;
      abort = 1'b1;
      #1;
      chk("t6_ready_abort",    32'(in_ready),    32'd0);
      chk("t6_level_before",   32'(level),       32'd2);
      cyc();
      abort = 1'b0;
      chk("t6_stop",           32'(timer_stop),  32'd1);
      chk("t6_flushed",        32'(level),       32'd0);
      cyc();
      chk("t6_idle",           32'(busy),        32'd0);
      chk("t6_one_stop",       32'(n_stop - s_stop), 32'd1);
      chk("t6_no_seq_done",    32'(n_sdone - s_sd),  32'd0);
      chk("t6_completed",      32'(completed),   32'd9);
      $display("txn t6: abort flushed queue");

      // Asynchronous reset mid-run
      push_word(8'h20);
      push_word(8'h21);
      cyc();
      cyc();
      chk("t7_busy_before",    32'(busy),        32'd1);
      chk("t7_level_before",   32'(level),       32'd1);
      rst = 1'b1;
      #1;
      chk_reset("t7_async");
      cyc();
      rst = 1'b0;
      cyc();
      $display("txn t7: asynchronous reset mid-run");

      // Randomized traffic against a behavioural timer and expected-period queue
      while (!(sent == N_RND && !in_valid && !busy && level == 0) && budget < RND_BUDGET) begin
         cyc();
         budget++;
         chk("rnd_seq_done", 32'(seq_done), 32'(timer_done));
         timer_done = 1'b0;
         if (timer_start) begin
            if (held) begin
               chk("rnd_resume_data", 32'(timer_data), 32'(cur));
               held = 1'b0;
               if (cnt < 2) cnt = 2;
            end else begin
               while (exp_q.size() > 0 && exp_q[0] == '0) void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  chk("rnd_unexpected_start", 32'(timer_start), 32'd0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("rnd_start_data", 32'(timer_data), 32'(cur));
                  cnt = int'(cur);
                  n_txn++;
                  $display("txn r%0d: period %0d started", n_txn, cur);
               end
            end
            run = 1'b1;
         end else if (timer_stop) begin
            run  = 1'b0;
            held = 1'b1;
         end else if (run) begin
            cnt--;
            if (cnt <= 0) begin
               timer_done = 1'b1;
               run = 1'b0;
               n_done++;
            end
         end
         if (pause) begin
            if ($urandom_range(3) == 0) pause = 1'b0;
         end else if (run && cnt > 3 && $urandom_range(15) == 0) begin
            pause = 1'b1;
         end
         if (in_valid && accepted) in_valid = 1'b0;
         if (!in_valid && sent < N_RND && $urandom_range(2) == 0) begin
            in_valid = 1'b1;
            in_data  = ($urandom_range(7) == 0) ? DW'(0) : DW'($urandom_range(12, 2));
         end
         #1;
         accepted = in_valid && in_ready;
         if (accepted) begin
            exp_q.push_back(in_data);
            sent++;
         end
      end
      pause = 1'b0;
      chk("rnd_within_budget", 32'(budget < RND_BUDGET), 32'd1);
      leftover = 0;
      foreach (exp_q[i]) if (exp_q[i] != '0) leftover++;
      chk("rnd_all_issued",   32'(leftover),  32'd0);
      chk("rnd_completed",    32'(completed), 32'(n_done));
      chk("rnd_final_level",  32'(level),     32'd0);
      chk("rnd_final_busy",   32'(busy),      32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
